word_serializer: RTL

- Downstream consumer of the word-split stage.
- Takes one BUS_SIZE bus per transaction, with a per-word control mask and an error flag.
- Emits only the flagged words, one per cycle, most-significant word first, over a valid/ready stream.
- Errored buses are dropped and counted. The block holds a single-entry buffer.

---
 rtl/word_serializer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/word_serializer.sv
// Serializes the flagged words of each accepted bus, most-significant word first.
// Optional macro WORD_PARITY_EN widens word_out by one even-parity MSB.
module word_serializer #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_SIZE-1:0]  data_in_bus,
  input  logic [WORD_NUM-1:0]  control_in,
  input  logic                 error_in,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef WORD_PARITY_EN
  output logic [WORD_SIZE:0]   word_out,
`else
  output logic [WORD_SIZE-1:0] word_out,
`endif
  output logic [IDX_W-1:0]     word_idx,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 word_last,
  output logic [7:0]           drop_count,
  output logic                 drop_pulse
);

`ifdef WORD_PARITY_EN
  localparam int OUT_W = WORD_SIZE + 1;
`else
  localparam int OUT_W = WORD_SIZE;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BUS_SIZE-1:0]   data_q, data_d;
  logic [WORD_NUM-1:0]   mask_q, mask_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic                  in_ready_q, in_ready_d;
  logic                  word_valid_q, word_valid_d;
  logic [OUT_W-1:0]      word_out_q, word_out_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic                  word_last_q, word_last_d;

  function automatic logic [IDX_W-1:0] hi_idx(input logic [WORD_NUM-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < WORD_NUM; k++) begin
      r = m[k] ? IDX_W'(k) : r;
    end
    return r;
  endfunction

  function automatic logic [WORD_SIZE-1:0] pick_word(input logic [BUS_SIZE-1:0] d,
                                                     input logic [IDX_W-1:0]    i);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    for (int k = 0; k < WORD_NUM; k++) begin
      w = (i == IDX_W'(k)) ? d[k*WORD_SIZE +: WORD_SIZE] : w;
    end
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] fmt_out(input logic [WORD_SIZE-1:0] w);
`ifdef WORD_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // Next-state: accept/drop in IDLE, retire one mask bit per transfer in SEND
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mask_d       = mask_q;
    drop_count_d = drop_count_q;
    drop_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (error_in) begin
            drop_pulse_d = 1'b1;
            drop_count_d = (drop_count_q == 8'hFF) ? drop_count_q : drop_count_q + 8'd1;
          end else if (control_in != '0) begin
            data_d  = data_in_bus;
            mask_d  = control_in;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (word_ready) begin
          for (int k = 0; k < WORD_NUM; k++) begin
            mask_d[k] = (word_idx_q == IDX_W'(k)) ? 1'b0 : mask_q[k];
          end
          state_d = word_last_q ? IDLE : SEND;
        end else begin
          mask_d = mask_q;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // Output next values derived from the next state so every output is a flop
  always_comb begin
    in_ready_d   = (state_d == IDLE);
    word_valid_d = (state_d == SEND);
    if (state_d == SEND) begin
      word_idx_d  = hi_idx(mask_d);
      word_out_d  = fmt_out(pick_word(data_d, hi_idx(mask_d)));
      word_last_d = ($countones(mask_d) == 32'sd1);
    end else begin
      word_idx_d  = '0;
      word_out_d  = '0;
      word_last_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      mask_q       <= '0;
      drop_count_q <= 8'd0;
      drop_pulse_q <= 1'b0;
      in_ready_q   <= 1'b1;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_idx_q   <= '0;
      word_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
      in_ready_q   <= in_ready_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
      word_idx_q   <= word_idx_d;
      word_last_q  <= word_last_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_out_q;
  assign word_idx   = word_idx_q;
  assign word_last  = word_last_q;
  assign drop_count = drop_count_q;
  assign drop_pulse = drop_pulse_q;

endmodule
